dct2_job_scheduler: RTL and testbench
=====================================

// Module: dct2_job_scheduler
// PURPOSE
//  Arbitrates 2-D DCT-II transform jobs from NREQ requesters and sequences the shared 2-D engine.
//  Grants round-robin and latches the job's size code.
//  Drives a vertical (column) pass, then a transpose turnaround, then a horizontal (row) pass.
//  Returns a one-cycle done pulse tagged with the requester index.
// PARAMETERS
//  NREQ         4   number of requesters (2..8)
//  TURN_CYCLES  2   idle cycles between passes for transpose-buffer turnaround (>=1)
// PORTS
//  clk          in   1             clock
//  reset        in   1             synchronous, active-high
//  req_valid    in   NREQ          per-requester job valid
//  req_size     in   2*NREQ        per-requester size code; slice i = [2i+1:2i]; 0/1/2/3 -> T=4/8/16/32
//  req_ready    out  NREQ          one-hot accept; combinational, asserted only in IDLE
//  eng_stall    in   1             engine back-pressure; freezes pass progress
//  eng_enable   out  1             engine processes line line_idx this cycle
//  eng_dir      out  1             1 = vertical pass, 0 = horizontal pass
//  eng_size     out  2             latched size code of the active job
//  line_idx     out  5             current row/column index, 0..T-1
//  busy         out  1             high in every state except IDLE
//  done         out  1             one-cycle pulse when job complete
//  done_id      out  clog2(NREQ)   requester index of the finished job; valid with done
// BEHAVIOUR
//  - Reset values: state=IDLE, rr_ptr=0, all outputs 0.
//  - reset mid-job discards the job with no done pulse; the next cycle is IDLE.
//  - States: IDLE, VPASS, TURN, HPASS, DONE.
//  - Size: T = 4 << size_code; line counter is 5 bits, so size 3 ends at idx 31 without overflow.
//  - IDLE: winner = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NREQ.
//      - req_ready[winner]=1; the handshake completes this cycle.
//      - On handshake: latch size and id; idx<=0; rr_ptr<=(winner+1) mod NREQ; next VPASS.
//      - No valid request: stay in IDLE; rr_ptr unchanged.
//      - req_ready is 0 in all other states and for all non-winners.
//  - VPASS: eng_dir=1; eng_enable=!eng_stall.
//      - idx increments only on non-stalled cycles.
//      - Non-stalled cycle at idx==T-1: go to TURN, turn counter <= TURN_CYCLES-1.
//  - TURN: eng_enable=0; eng_dir=1; count down; at 0 go to HPASS with idx<=0.
//      - eng_stall is ignored in TURN.
//  - HPASS: eng_dir=0; otherwise same as VPASS.
//      - Non-stalled cycle at idx==T-1: go to DONE.
//  - DONE: done=1 and done_id=latched id for exactly 1 cycle; eng_enable=0; eng_dir=0; next IDLE.
//      - A new grant occurs no earlier than the cycle after DONE.
//  - line_idx=idx in VPASS/HPASS and 0 elsewhere.
//  - eng_size holds the latched code from accept until the next accept; reset clears it to 0.
//  - Latency without stalls: accept at cycle A.
//      - VPASS covers A+1..A+T.
//      - TURN covers A+T+1..A+T+TURN_CYCLES.
//      - HPASS covers the next T cycles.
//      - done at A+2T+TURN_CYCLES+1.
//  - Each stalled cycle in VPASS/HPASS adds exactly one cycle; idx, eng_dir and eng_size hold.
//  - req_size/req_valid changes after accept have no effect on the active job.
//  - busy = (state != IDLE).
// TESTING
//  1. Reset; req_valid=0001, size 0 -> req_ready=0001 same cycle.
//     eng_enable with dir=1 for 4 cycles (idx 0..3), 2 idle cycles, dir=0 for 4 cycles.
//     done=1, done_id=0 at A+11.
//  2. All four requesters valid continuously, size 1 -> grants in order 0,1,2,3,0.
//     Consecutive accepts 20 cycles apart (T=8: 1+8+2+8+1 per job).
//  3. Size 3 job; eng_stall high for 3 cycles at VPASS idx 10 -> idx holds at 10, eng_enable=0.
//     done delayed by exactly 3 cycles (at A+70); idx reaches 31, never 0 mid-pass.
//  4. reset asserted during HPASS idx 5 -> next cycle IDLE, all outputs 0.
//     No done pulse; rr_ptr=0.
//  5. Requester 2 alone while rr_ptr=3 -> grant to 2 (wrap-around); rr_ptr becomes 3.
//  6. Change req_size of the active requester mid-VPASS from 0 to 3 -> pass length stays T=4.
//     eng_size stays 0.

Source files
------------

// File: rtl/dct2_job_scheduler.sv
// dct2_job_scheduler: round-robin arbiter that sequences 2-D DCT-II jobs as vertical pass, turnaround, horizontal pass, done.
// Ports: clk/reset (sync, active-high); req_valid/req_size/req_ready requester handshake;
// eng_stall engine back-pressure; eng_enable/eng_dir/eng_size/line_idx engine control;
// busy (not idle); done/done_id one-cycle completion pulse with requester index.
module dct2_job_scheduler #(
  parameter int NREQ = 4,
  parameter int TURN_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [2*NREQ-1:0]       req_size,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    eng_stall,
  output logic                    eng_enable,
  output logic                    eng_dir,
  output logic [1:0]              eng_size,
  output logic [4:0]              line_idx,
  output logic                    busy,
  output logic                    done,
  output logic [$clog2(NREQ)-1:0] done_id
);
  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(TURN_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, VPASS, TURN, HPASS, DONE} state_t;
  state_t state, state_nx;
  logic [IW-1:0] rr_ptr, id_q, winner;
  logic [1:0] size_q;
  logic [4:0] idx;
  logic [TW-1:0] turn_cnt;
  logic found, last, in_pass;
  // Scan offsets from high to low so the smallest offset from rr_ptr wins.
  always_comb begin
    winner = '0;
    found = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_ptr) + k) % NREQ]) begin
        winner = IW'((int'(rr_ptr) + k) % NREQ);
        found = 1'b1;
      end
    end
  end
  // T-1 for T = 4 << size is a run of (size+2) ones.
  assign last = idx == (5'h1f >> (2'd3 - size_q));
  assign in_pass = state == VPASS || state == HPASS;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  state_nx = found ? VPASS : IDLE;
      VPASS: state_nx = (!eng_stall && last) ? TURN : VPASS;
      TURN:  state_nx = turn_cnt == '0 ? HPASS : TURN;
      HPASS: state_nx = (!eng_stall && last) ? DONE : HPASS;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      id_q <= '0;
      size_q <= '0;
      idx <= '0;
      turn_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && found) begin
        size_q <= req_size[2*winner +: 2];
        id_q <= winner;
        idx <= '0;
        rr_ptr <= winner == IW'(NREQ - 1) ? '0 : winner + 1'b1;
      end
      if (in_pass && !eng_stall) idx <= last ? 5'd0 : idx + 5'd1;
      if (state == VPASS) turn_cnt <= TW'(TURN_CYCLES - 1);
      if (state == TURN) turn_cnt <= turn_cnt - 1'b1;
    end
  end
  assign req_ready = (state == IDLE && found) ? {{(NREQ-1){1'b0}}, 1'b1} << winner : '0;
  assign eng_enable = in_pass && !eng_stall;
  assign eng_dir = state == VPASS || state == TURN;
  assign eng_size = size_q;
  assign line_idx = in_pass ? idx : 5'd0;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign done_id = done ? id_q : '0;
endmodule

// File: tb/tb_dct2_job_scheduler.sv
// tb_dct2_job_scheduler: directed self-checking bench for dct2_job_scheduler.
module tb_dct2_job_scheduler;
  logic clk = 0, reset = 1, eng_stall = 0;
  logic [3:0] req_valid = 0, req_ready;
  logic [7:0] req_size = 0;
  logic eng_enable, eng_dir, busy, done;
  logic [1:0] eng_size, done_id;
  logic [4:0] line_idx;
  int vectors = 0, errs = 0, cnt = 0, a = 0, prev_a = 0;
  dct2_job_scheduler dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_size(req_size), .req_ready(req_ready),
    .eng_stall(eng_stall), .eng_enable(eng_enable), .eng_dir(eng_dir), .eng_size(eng_size),
    .line_idx(line_idx), .busy(busy), .done(done), .done_id(done_id)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  task automatic do_reset();
    reset = 1; req_valid = 0; eng_stall = 0;
    cyc(); cyc();
    reset = 0;
    #1;
    chk("rst_busy", busy, 0); chk("rst_en", eng_enable, 0); chk("rst_dir", eng_dir, 0);
    chk("rst_size", eng_size, 0); chk("rst_idx", line_idx, 0); chk("rst_done", done, 0);
    chk("rst_id", done_id, 0); chk("rst_ready", req_ready, 0);
  endtask
  task automatic accept(input logic [3:0] v, input logic [7:0] sz, input logic [3:0] exp);
    req_valid = v; req_size = sz;
    #1;
    chk("grant", req_ready, exp);
    prev_a = a; a = cnt;
  endtask
  // Walks one job from the cycle after accept through the following idle cycle.
  task automatic job(input int t, input int id, input int sz, input int sk, input int sn, input bit chg, input bit hold);
    for (int k = 0; k < t; k++) begin
      if (k == sk)
        for (int s = 0; s < sn; s++) begin
          cyc(); eng_stall = 1; #1;
          chk("stall_en", eng_enable, 0); chk("stall_idx", line_idx, k); chk("stall_dir", eng_dir, 1);
          chk("stall_size", eng_size, sz);
        end
      cyc();
      eng_stall = 0;
      if (!hold) req_valid = 0;
      if (chg && k == 1) req_size = 8'hff;
      #1;
      chk("v_en", eng_enable, 1); chk("v_dir", eng_dir, 1); chk("v_idx", line_idx, k);
      chk("v_size", eng_size, sz); chk("v_ready", req_ready, 0); chk("v_busy", busy, 1); chk("v_done", done, 0);
    end
    for (int k = 0; k < 2; k++) begin
      cyc();
      chk("t_en", eng_enable, 0); chk("t_dir", eng_dir, 1); chk("t_idx", line_idx, 0); chk("t_busy", busy, 1);
    end
    for (int k = 0; k < t; k++) begin
      cyc();
      chk("h_en", eng_enable, 1); chk("h_dir", eng_dir, 0); chk("h_idx", line_idx, k); chk("h_done", done, 0);
    end
    cyc();
    chk("d_done", done, 1); chk("d_id", done_id, id); chk("d_en", eng_enable, 0); chk("d_dir", eng_dir, 0);
    chk("d_lat", cnt - a, 2 * t + 3 + sn);
    cyc();
    chk("i_done", done, 0); chk("i_busy", busy, 0);
  endtask
  initial begin
    do_reset();
    // single requester, T=4, done at A+11
    accept(4'b0001, 8'h00, 4'b0001);
    job(4, 0, 0, -1, 0, 0, 0);
    // round robin with all requesters valid, T=8, accepts 20 cycles apart
    do_reset();
    for (int g = 0; g < 5; g++) begin
      accept(4'b1111, 8'h55, 4'b0001 << (g % 4));
      if (g > 0) chk("rr_gap", a - prev_a, 20);
      job(8, g % 4, 1, -1, 0, 0, 1);
    end
    // size 3 with 3 stall cycles at VPASS idx 10, done at A+70
    do_reset();
    accept(4'b0010, 8'h0c, 4'b0010);
    job(32, 1, 3, 10, 3, 0, 0);
    // reset during HPASS idx 5 (rr_ptr was 2)
    accept(4'b1000, 8'h40, 4'b1000);
    for (int n = 1; n <= 16; n++) begin
      cyc();
      req_valid = 0;
    end
    #1;
    chk("h5_idx", line_idx, 5); chk("h5_dir", eng_dir, 0);
    reset = 1;
    cyc();
    chk("mr_busy", busy, 0); chk("mr_en", eng_enable, 0); chk("mr_done", done, 0); chk("mr_size", eng_size, 0);
    chk("mr_idx", line_idx, 0); chk("mr_dir", eng_dir, 0); chk("mr_id", done_id, 0);
    reset = 0;
    cyc();
    chk("mr_nodone", done, 0); chk("mr_idle", busy, 0);
    accept(4'b1010, 8'h00, 4'b0010);
    job(4, 1, 0, -1, 0, 0, 0);
    accept(4'b0100, 8'h00, 4'b0100);
    job(4, 2, 0, -1, 0, 0, 0);
    // wrap-around: requester 2 alone with rr_ptr=3, rr_ptr stays 3
    accept(4'b0100, 8'h00, 4'b0100);
    job(4, 2, 0, -1, 0, 0, 0);
    // rr_ptr=3 picks 3 over 1; size change mid-VPASS is ignored
    accept(4'b1010, 8'h00, 4'b1000);
    job(4, 3, 0, -1, 0, 1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
